// File: rtl/kbd_playback_ctrl.sv
// kbd_playback_ctrl
//   Keyboard-driven playback controller for flash audio. Decodes ASCII keys
//   (either case) into play / pause / direction / restart / speed commands,
//   generates the sample-rate tick and owns the flash word address counter.
//
//   Build option: define LOOP_PLAYBACK_EN to wrap the address at either end
//   and keep playing. Without it, playback holds the boundary address and
//   pauses after that read completes.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   key         ASCII code of the last key
//   key_strobe  1-cycle pulse: key holds a new press
//   read_ack    1-cycle pulse: flash read of read_addr complete
//   read_req    read request, held high until read_ack
//   read_addr   flash word address to read
//   dir         0 = forward, 1 = backward
//   playing     1 while in PLAY or WAIT_ACK
//   restart     1-cycle pulse when the address is reloaded
//   rate_div    current sample-rate divisor
//
// Read handshake: read_req rises the cycle after a tick and stays high with
// read_addr stable until read_ack is sampled high; read_req drops the cycle
// after that sample. read_ack while no request is outstanding is ignored.
module kbd_playback_ctrl #(
    parameter int              ADDR_W    = 23,
    parameter logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(20'h7FFFF),
    parameter int              DIV_W     = 16,
    parameter int              DIV_RESET = 1136,
    parameter int              DIV_STEP  = 64,
    parameter int              DIV_MIN   = 256,
    parameter int              DIV_MAX   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        key,
    input  logic              key_strobe,
    input  logic              read_ack,
    output logic              read_req,
    output logic [ADDR_W-1:0] read_addr,
    output logic              dir,
    output logic              playing,
    output logic              restart,
    output logic [DIV_W-1:0]  rate_div
);

    typedef enum logic [2:0] {
        S_IDLE, S_PLAY, S_WAIT_ACK, S_PAUSE, S_RESTART
    } state_t;

    localparam logic [DIV_W-1:0]  DIV_RESET_V = DIV_W'(DIV_RESET);
    localparam logic [DIV_W-1:0]  DIV_STEP_V  = DIV_W'(DIV_STEP);
    localparam logic [DIV_W-1:0]  DIV_MIN_V   = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0]  DIV_MAX_V   = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0]  DIV_DN_LIM  = DIV_W'(DIV_MIN + DIV_STEP);
    localparam logic [DIV_W-1:0]  DIV_UP_LIM  = DIV_W'(DIV_MAX - DIV_STEP);
    localparam logic [DIV_W-1:0]  DIV_ONE     = DIV_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    state_t            state_q, state_n, ret_q, ret_n, mode_v;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              dir_q, dir_n;
    logic [DIV_W-1:0]  div_q, div_n;
    logic [DIV_W-1:0]  cur_div_q, cur_div_n;
    logic [DIV_W-1:0]  cnt_q, cnt_n;
    logic              pend_d_q, pend_d_n, pend_r_q, pend_r_n;
    logic              rr_v, stop_v, tick;

    // Fold lowercase letters onto uppercase so one compare covers both cases.
    logic [7:0] key_uc;
    assign key_uc = (key >= 8'h61 && key <= 8'h7A) ? (key - 8'h20) : key;

    logic is_e, is_d, is_f, is_b, is_r, is_u, is_s;
    assign is_e = key_strobe && (key_uc == 8'h45);
    assign is_d = key_strobe && (key_uc == 8'h44);
    assign is_f = key_strobe && (key_uc == 8'h46);
    assign is_b = key_strobe && (key_uc == 8'h42);
    assign is_r = key_strobe && (key_uc == 8'h52);
    assign is_u = key_strobe && (key_uc == 8'h55);
    assign is_s = key_strobe && (key_uc == 8'h53);

    // A pause or restart key in the same cycle wins over the tick.
    // cur_div_q is the divisor latched at the last wrap, so speed keys never
    // shorten a period already in progress.
    assign tick = (state_q == S_PLAY) && (cnt_q >= cur_div_q - DIV_ONE) && !is_d && !is_r;

    // Direction and speed apply in every state.
    always_comb begin
        dir_n = dir_q;
        if (is_f) dir_n = 1'b0;
        if (is_b) dir_n = 1'b1;

        div_n = div_q;
        if (is_u) div_n = (div_q >= DIV_DN_LIM) ? (div_q - DIV_STEP_V) : DIV_MIN_V;
        if (is_s) div_n = (div_q <= DIV_UP_LIM) ? (div_q + DIV_STEP_V) : DIV_MAX_V;
    end

    always_comb begin
        state_n  = state_q;
        ret_n    = ret_q;
        addr_n   = addr_q;
        cnt_n    = cnt_q;
        pend_d_n = pend_d_q;
        pend_r_n = pend_r_q;
        mode_v   = S_PLAY;
        rr_v     = 1'b0;
        stop_v   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_e) state_n = S_PLAY;
                else if (is_r) begin
                    state_n = S_RESTART;
                    ret_n   = S_IDLE;
                end
            end
            S_PLAY: begin
                if (is_d) state_n = S_PAUSE;
                else if (is_r) begin
                    state_n = S_RESTART;
                    ret_n   = S_PLAY;
                end else if (tick) begin
                    state_n = S_WAIT_ACK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + DIV_ONE;
                end
            end
            S_PAUSE: begin
                if (is_e) state_n = S_PLAY;
                else if (is_r) begin
                    state_n = S_RESTART;
                    ret_n   = S_PAUSE;
                end
            end
            S_WAIT_ACK: begin
                if (read_ack) begin
                    // Step the address with the direction in force at ack time.
                    if (!dir_q) begin
                        if (addr_q == ADDR_LAST) begin
`ifdef LOOP_PLAYBACK_EN
                            addr_n = '0;
`else
                            stop_v = 1'b1;
`endif
                        end else begin
                            addr_n = addr_q + ADDR_ONE;
                        end
                    end else begin
                        if (addr_q == '0) begin
`ifdef LOOP_PLAYBACK_EN
                            addr_n = ADDR_LAST;
`else
                            stop_v = 1'b1;
`endif
                        end else begin
                            addr_n = addr_q - ADDR_ONE;
                        end
                    end
                    // Ack completes first; a key in the same cycle then acts
                    // on the resulting mode.
                    mode_v = (pend_d_q || stop_v) ? S_PAUSE : S_PLAY;
                    rr_v   = pend_r_q;
                    if (is_e) mode_v = S_PLAY;
                    if (is_d) mode_v = S_PAUSE;
                    if (is_r) rr_v = 1'b1;
                    pend_d_n = 1'b0;
                    pend_r_n = 1'b0;
                    if (rr_v) begin
                        state_n = S_RESTART;
                        ret_n   = mode_v;
                    end else begin
                        state_n = mode_v;
                    end
                end else begin
                    if (is_d) pend_d_n = 1'b1;
                    if (is_r) pend_r_n = 1'b1;
                end
            end
            S_RESTART: begin
                state_n = ret_q;
                cnt_n   = '0;
            end
            default: state_n = S_IDLE;
        endcase

        // Reload the address on entry so it is already valid while restart=1.
        if (state_n == S_RESTART && state_q != S_RESTART)
            addr_n = dir_n ? ADDR_LAST : '0;
    end

    always_comb begin
        cur_div_n = cur_div_q;
        if (tick || state_q == S_IDLE || state_q == S_RESTART) cur_div_n = div_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            addr_q    <= '0;
            dir_q     <= 1'b0;
            div_q     <= DIV_RESET_V;
            cur_div_q <= DIV_RESET_V;
            cnt_q     <= '0;
            pend_d_q  <= 1'b0;
            pend_r_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            ret_q     <= ret_n;
            addr_q    <= addr_n;
            dir_q     <= dir_n;
            div_q     <= div_n;
            cur_div_q <= cur_div_n;
            cnt_q     <= cnt_n;
            pend_d_q  <= pend_d_n;
            pend_r_q  <= pend_r_n;
        end
    end

    assign read_req  = (state_q == S_WAIT_ACK);
    assign playing   = (state_q == S_PLAY) || (state_q == S_WAIT_ACK);
    assign restart   = (state_q == S_RESTART);
    assign read_addr = addr_q;
    assign dir       = dir_q;
    assign rate_div  = div_q;

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Testbench for kbd_playback_ctrl. Expected read addresses are queued when a
// read is anticipated and popped when the DUT raises read_req.
module tb_kbd_playback_ctrl;

    localparam int              ADDR_W    = 23;
    localparam logic [ADDR_W-1:0] ADDR_LAST = 23'h7FFFF;
    localparam int              DIV_W     = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        key = 8'h00;
    logic              key_strobe = 1'b0;
    logic              read_ack = 1'b0;
    logic              read_req;
    logic [ADDR_W-1:0] read_addr;
    logic              dir;
    logic              playing;
    logic              restart;
    logic [DIV_W-1:0]  rate_div;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [ADDR_W-1:0] exp_q[$];

    kbd_playback_ctrl dut (
        .clk(clk), .reset(reset), .key(key), .key_strobe(key_strobe),
        .read_ack(read_ack), .read_req(read_req), .read_addr(read_addr),
        .dir(dir), .playing(playing), .restart(restart), .rate_div(rate_div)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // driver tasks: all driving and sampling happens 1 time unit after posedge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] k);
        key = k;
        key_strobe = 1'b1;
        step(1);
        key_strobe = 1'b0;
        key = 8'h00;
    endtask

    task automatic await_req(input string name, input int limit);
        int n;
        n = 0;
        while (!read_req && n < limit) begin
            step(1);
            n++;
        end
        n_checks++;
        if (read_req !== 1'b1) begin
            $display("FAIL %s: read_req=%b after %0d cycles, required 1", name, read_req, limit);
            n_fail++;
        end
    endtask

    task automatic check_addr_pop(input string name);
        logic [ADDR_W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: no expected address queued, got %h", name, read_addr);
            n_fail++;
        end else begin
            e = exp_q.pop_front();
            if (read_addr !== e) begin
                $display("FAIL %s: read_addr=%h required %h", name, read_addr, e);
                n_fail++;
            end
        end
    endtask

    // Called with read_req high: compare address, ack after delay cycles.
    task automatic serve(input string name, input int delay);
        check_addr_pop(name);
        step(delay);
        read_ack = 1'b1;
        step(1);
        read_ack = 1'b0;
        n_checks++;
        if (read_req !== 1'b0) begin
            $display("FAIL %s_req_drop: read_req=%b required 0", name, read_req);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        n_checks++;
        if ({read_req, playing, restart, dir} !== 4'b0000 || read_addr !== '0 || rate_div !== 16'd1136) begin
            $display("FAIL reset_state: req=%b play=%b rst=%b dir=%b addr=%h div=%0d required 0 0 0 0 0 1136",
                     read_req, playing, restart, dir, read_addr, rate_div);
            n_fail++;
        end
        step(1000);
        n_checks++;
        if (read_req !== 1'b0 || playing !== 1'b0 || read_addr !== '0 || rate_div !== 16'd1136) begin
            $display("FAIL idle_1000: req=%b play=%b addr=%h div=%0d required 0 0 0 1136",
                     read_req, playing, read_addr, rate_div);
            n_fail++;
        end
    endtask

    task automatic test_play();
        int t_prev;
        send_key("e");
        t_prev = cyc;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ADDR_W'(i));
            await_req("play_req", 2000);
            n_checks++;
            if (cyc - t_prev != ((i == 0) ? 1136 : 1140)) begin
                $display("FAIL play_period: %0d cycles required %0d", cyc - t_prev, (i == 0) ? 1136 : 1140);
                n_fail++;
            end
            t_prev = cyc;
            serve("play_addr", 3);
            n_checks++;
            if (read_addr !== ADDR_W'(i + 1) || playing !== 1'b1) begin
                $display("FAIL play_step: addr=%h play=%b required %h 1", read_addr, playing, i + 1);
                n_fail++;
            end
        end
        send_key("D");
        n_checks++;
        if (playing !== 1'b0 || read_addr !== 23'd4) begin
            $display("FAIL pause: play=%b addr=%h required 0 4", playing, read_addr);
            n_fail++;
        end
        send_key("x");
        send_key("Q");
        step(50);
        n_checks++;
        if (playing !== 1'b0 || read_req !== 1'b0 || rate_div !== 16'd1136 || dir !== 1'b0) begin
            $display("FAIL ignored_keys: play=%b req=%b div=%0d dir=%b required 0 0 1136 0",
                     playing, read_req, rate_div, dir);
            n_fail++;
        end
    endtask

    task automatic test_speed();
        int exp_div;
        exp_div = 1136;
        for (int i = 0; i < 40; i++) begin
            send_key((i % 2) ? "u" : "U");
            exp_div = (exp_div - 64 < 256) ? 256 : exp_div - 64;
            n_checks++;
            if (rate_div !== DIV_W'(exp_div)) begin
                $display("FAIL speed_u: rate_div=%0d required %0d", rate_div, exp_div);
                n_fail++;
            end
        end
        for (int i = 0; i < 70; i++) begin
            send_key((i % 2) ? "S" : "s");
            exp_div = (exp_div + 64 > 4096) ? 4096 : exp_div + 64;
            n_checks++;
            if (rate_div !== DIV_W'(exp_div)) begin
                $display("FAIL speed_s: rate_div=%0d required %0d", rate_div, exp_div);
                n_fail++;
            end
        end
        for (int i = 0; i < 60; i++) send_key("u");
        n_checks++;
        if (rate_div !== 16'd256) begin
            $display("FAIL speed_fast: rate_div=%0d required 256", rate_div);
            n_fail++;
        end
    endtask

    task automatic test_restart_pending();
        send_key("e");
        exp_q.push_back(23'd4);
        await_req("rp_req", 3000);
        check_addr_pop("rp_addr");
        send_key("R");
        step(2);
        n_checks++;
        if (restart !== 1'b0 || read_req !== 1'b1 || read_addr !== 23'd4) begin
            $display("FAIL rp_hold: rst=%b req=%b addr=%h required 0 1 4", restart, read_req, read_addr);
            n_fail++;
        end
        read_ack = 1'b1;
        step(1);
        read_ack = 1'b0;
        n_checks++;
        if (restart !== 1'b1 || read_addr !== '0 || read_req !== 1'b0) begin
            $display("FAIL rp_restart: rst=%b addr=%h req=%b required 1 0 0", restart, read_addr, read_req);
            n_fail++;
        end
        step(1);
        n_checks++;
        if (restart !== 1'b0 || playing !== 1'b1 || read_addr !== '0) begin
            $display("FAIL rp_after: rst=%b play=%b addr=%h required 0 1 0", restart, playing, read_addr);
            n_fail++;
        end
    endtask

    task automatic test_ack_key();
        int t0;
        exp_q.push_back(23'd0);
        await_req("ak_req0", 1000);
        t0 = cyc;
        serve("ak_addr0", 3);
        exp_q.push_back(23'd1);
        await_req("ak_req1", 1000);
        n_checks++;
        if (cyc - t0 != 260) begin
            $display("FAIL fast_period: %0d cycles required 260", cyc - t0);
            n_fail++;
        end
        check_addr_pop("ak_addr1");
        step(3);
        read_ack = 1'b1;
        key = "d";
        key_strobe = 1'b1;
        step(1);
        read_ack = 1'b0;
        key_strobe = 1'b0;
        n_checks++;
        if (read_addr !== 23'd2 || playing !== 1'b0 || read_req !== 1'b0) begin
            $display("FAIL ack_and_d: addr=%h play=%b req=%b required 2 0 0", read_addr, playing, read_req);
            n_fail++;
        end
        step(400);
        n_checks++;
        if (read_req !== 1'b0 || read_addr !== 23'd2) begin
            $display("FAIL ack_and_d_hold: req=%b addr=%h required 0 2", read_req, read_addr);
            n_fail++;
        end
    endtask

    task automatic test_reverse();
        send_key("E");
        for (int a = 2; a < 5; a++) begin
            exp_q.push_back(ADDR_W'(a));
            await_req("rev_req", 1000);
            serve("rev_addr", 1);
        end
        send_key("d");
        n_checks++;
        if (read_addr !== 23'd5 || playing !== 1'b0) begin
            $display("FAIL rev_pause5: addr=%h play=%b required 5 0", read_addr, playing);
            n_fail++;
        end
        send_key("B");
        n_checks++;
        if (dir !== 1'b1) begin
            $display("FAIL rev_dir: dir=%b required 1", dir);
            n_fail++;
        end
        send_key("r");
        n_checks++;
        if (restart !== 1'b1 || read_addr !== ADDR_LAST || playing !== 1'b0) begin
            $display("FAIL rev_restart: rst=%b addr=%h play=%b required 1 %h 0", restart, read_addr, playing, ADDR_LAST);
            n_fail++;
        end
        step(1);
        n_checks++;
        if (restart !== 1'b0 || playing !== 1'b0 || read_addr !== ADDR_LAST) begin
            $display("FAIL rev_after: rst=%b play=%b addr=%h required 0 0 %h", restart, playing, read_addr, ADDR_LAST);
            n_fail++;
        end
        step(300);
        n_checks++;
        if (read_req !== 1'b0) begin
            $display("FAIL rev_paused: read_req=%b required 0", read_req);
            n_fail++;
        end
    endtask

    task automatic test_boundary();
        send_key("f");
        send_key("E");
        exp_q.push_back(ADDR_LAST);
        await_req("bnd_fwd_req", 1000);
        serve("bnd_fwd_addr", 3);
        n_checks++;
`ifdef LOOP_PLAYBACK_EN
        if (read_addr !== '0 || playing !== 1'b1) begin
            $display("FAIL bnd_fwd: addr=%h play=%b required 0 1", read_addr, playing);
            n_fail++;
        end
`else
        if (read_addr !== ADDR_LAST || playing !== 1'b0) begin
            $display("FAIL bnd_fwd: addr=%h play=%b required %h 0", read_addr, playing, ADDR_LAST);
            n_fail++;
        end
        step(400);
        n_checks++;
        if (read_req !== 1'b0 || read_addr !== ADDR_LAST) begin
            $display("FAIL bnd_fwd_hold: req=%b addr=%h required 0 %h", read_req, read_addr, ADDR_LAST);
            n_fail++;
        end
`endif
        send_key("r");
        n_checks++;
        if (restart !== 1'b1 || read_addr !== '0) begin
            $display("FAIL bnd_restart: rst=%b addr=%h required 1 0", restart, read_addr);
            n_fail++;
        end
        send_key("b");
`ifndef LOOP_PLAYBACK_EN
        send_key("e");
`endif
        exp_q.push_back(23'd0);
        await_req("bnd_bwd_req", 1000);
        serve("bnd_bwd_addr", 3);
        n_checks++;
`ifdef LOOP_PLAYBACK_EN
        if (read_addr !== ADDR_LAST || playing !== 1'b1) begin
            $display("FAIL bnd_bwd: addr=%h play=%b required %h 1", read_addr, playing, ADDR_LAST);
            n_fail++;
        end
`else
        if (read_addr !== '0 || playing !== 1'b0) begin
            $display("FAIL bnd_bwd: addr=%h play=%b required 0 0", read_addr, playing);
            n_fail++;
        end
`endif
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        send_key("e");
        exp_q.push_back(23'd0);
        await_req("rm_req", 2000);
        check_addr_pop("rm_addr");
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_checks++;
        if (read_req !== 1'b0 || playing !== 1'b0 || read_addr !== '0 || rate_div !== 16'd1136 || dir !== 1'b0) begin
            $display("FAIL reset_mid: req=%b play=%b addr=%h div=%0d dir=%b required 0 0 0 1136 0",
                     read_req, playing, read_addr, rate_div, dir);
            n_fail++;
        end
        read_ack = 1'b1;
        step(1);
        read_ack = 1'b0;
        n_checks++;
        if (read_addr !== '0 || read_req !== 1'b0 || playing !== 1'b0) begin
            $display("FAIL stray_ack: addr=%h req=%b play=%b required 0 0 0", read_addr, read_req, playing);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_play();
        test_speed();
        test_restart_pending();
        test_ack_key();
        test_reverse();
        test_boundary();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
